// File: rtl/axis_stat_decoder.sv
// Receives the 8-bit statistics report stream and reassembles each frame into
// parallel tag / tick / byte / frame count fields behind a valid/ready register.
module axis_stat_decoder #(
   parameter int TAG_ENABLE         = 1,
   parameter int TAG_WIDTH          = 16,
   parameter int TICK_COUNT_ENABLE  = 1,
   parameter int TICK_COUNT_WIDTH   = 32,
   parameter int BYTE_COUNT_ENABLE  = 1,
   parameter int BYTE_COUNT_WIDTH   = 32,
   parameter int FRAME_COUNT_ENABLE = 1,
   parameter int FRAME_COUNT_WIDTH  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic                         s_axis_tlast,
   input  logic                         s_axis_tuser,
   output logic [TAG_WIDTH-1:0]         m_tag,
   output logic [TICK_COUNT_WIDTH-1:0]  m_tick_count,
   output logic [BYTE_COUNT_WIDTH-1:0]  m_byte_count,
   output logic [FRAME_COUNT_WIDTH-1:0] m_frame_count,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         busy,
   output logic                         error_short,
   output logic                         error_long,
   output logic                         error_bad
);

   localparam int TAG_BYTES   = (TAG_ENABLE != 0)         ? (TAG_WIDTH + 7) / 8         : 0;
   localparam int TICK_BYTES  = (TICK_COUNT_ENABLE != 0)  ? (TICK_COUNT_WIDTH + 7) / 8  : 0;
   localparam int BYTE_BYTES  = (BYTE_COUNT_ENABLE != 0)  ? (BYTE_COUNT_WIDTH + 7) / 8  : 0;
   localparam int FRAME_BYTES = (FRAME_COUNT_ENABLE != 0) ? (FRAME_COUNT_WIDTH + 7) / 8 : 0;
   // At least one field must be enabled; a zero-length frame is not meaningful.
   localparam int TOTAL_LENGTH = TAG_BYTES + TICK_BYTES + BYTE_BYTES + FRAME_BYTES;

   // The last byte received sits in the low bits, so fields are addressed from the frame tail.
   localparam int FRAME_OFF = 0;
   localparam int BYTE_OFF  = FRAME_OFF + FRAME_BYTES * 8;
   localparam int TICK_OFF  = BYTE_OFF + BYTE_BYTES * 8;
   localparam int TAG_OFF   = TICK_OFF + TICK_BYTES * 8;

   localparam int SR_W  = TOTAL_LENGTH * 8;
   localparam int PTR_W = $clog2(TOTAL_LENGTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TOTAL_LENGTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t                         state_q;
   logic [PTR_W-1:0]               ptr_q;
   logic [SR_W-1:0]                sr_q;
   logic [SR_W-1:0]                sr_d;
   logic                           m_valid_q;
   logic                           busy_q;
   logic                           error_short_q;
   logic                           error_long_q;
   logic                           error_bad_q;
   logic [TAG_WIDTH-1:0]           m_tag_q;
   logic [TAG_WIDTH-1:0]           m_tag_d;
   logic [TICK_COUNT_WIDTH-1:0]    m_tick_q;
   logic [TICK_COUNT_WIDTH-1:0]    m_tick_d;
   logic [BYTE_COUNT_WIDTH-1:0]    m_byte_q;
   logic [BYTE_COUNT_WIDTH-1:0]    m_byte_d;
   logic [FRAME_COUNT_WIDTH-1:0]   m_frame_q;
   logic [FRAME_COUNT_WIDTH-1:0]   m_frame_d;
   logic                           accept;

   // Pending results block the input, so a decoded frame is never overwritten.
   assign s_axis_tready = !m_valid_q;
   assign accept        = s_axis_tvalid && s_axis_tready;

   // Shifted view including the byte on the bus, so the final byte loads in the same edge.
   assign sr_d = (sr_q << 8) | SR_W'(s_axis_tdata);

   if (TAG_ENABLE != 0) begin : g_tag
      assign m_tag_d = sr_d[TAG_OFF +: TAG_WIDTH];
   end else begin : g_no_tag
      assign m_tag_d = '0;
   end

   if (TICK_COUNT_ENABLE != 0) begin : g_tick
      assign m_tick_d = sr_d[TICK_OFF +: TICK_COUNT_WIDTH];
   end else begin : g_no_tick
      assign m_tick_d = '0;
   end

   if (BYTE_COUNT_ENABLE != 0) begin : g_byte
      assign m_byte_d = sr_d[BYTE_OFF +: BYTE_COUNT_WIDTH];
   end else begin : g_no_byte
      assign m_byte_d = '0;
   end

   if (FRAME_COUNT_ENABLE != 0) begin : g_frame
      assign m_frame_d = sr_d[FRAME_OFF +: FRAME_COUNT_WIDTH];
   end else begin : g_no_frame
      assign m_frame_d = '0;
   end

   // NOTE: the shift register has no reset; it is only read after a full frame has refilled it.
   always_ff @(posedge clk) begin
      if (accept && state_q != DROP) begin
         sr_q <= sr_d;
      end
   end

   // NOTE: every register here uses <= so all next-state terms read pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         ptr_q         <= '0;
         m_valid_q     <= 1'b0;
         error_short_q <= 1'b0;
         error_long_q  <= 1'b0;
         error_bad_q   <= 1'b0;
         m_tag_q       <= '0;
         m_tick_q      <= '0;
         m_byte_q      <= '0;
         m_frame_q     <= '0;
      end else begin
         error_short_q <= 1'b0;
         error_long_q  <= 1'b0;
         error_bad_q   <= 1'b0;

         if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
         end

         if (accept) begin
            case (state_q)
               IDLE, RECV: begin
                  if (ptr_q == LAST_PTR) begin
                     ptr_q <= '0;
                     if (s_axis_tlast) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (s_axis_tuser) begin
                           error_bad_q <= 1'b1;
                        end else begin
                           m_valid_q <= 1'b1;
                           m_tag_q   <= m_tag_d;
                           m_tick_q  <= m_tick_d;
                           m_byte_q  <= m_byte_d;
                           m_frame_q <= m_frame_d;
                        end
                     end else begin
                        state_q      <= DROP;
                        busy_q       <= 1'b1;
                        error_long_q <= 1'b1;
                     end
                  end else if (s_axis_tlast) begin
                     ptr_q         <= '0;
                     state_q       <= IDLE;
                     busy_q        <= 1'b0;
                     error_short_q <= 1'b1;
                  end else begin
                     ptr_q   <= ptr_q + PTR_W'(1);
                     state_q <= RECV;
                     busy_q  <= 1'b1;
                  end
               end
               DROP: begin
                  if (s_axis_tlast) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  ptr_q   <= '0;
               end
            endcase
         end
      end
   end

   assign m_valid       = m_valid_q;
   assign busy          = busy_q;
   assign error_short   = error_short_q;
   assign error_long    = error_long_q;
   assign error_bad     = error_bad_q;
   assign m_tag         = m_tag_q;
   assign m_tick_count  = m_tick_q;
   assign m_byte_count  = m_byte_q;
   assign m_frame_count = m_frame_q;

endmodule

// File: tb/tb_axis_stat_decoder.sv
// Self-checking bench: a default decoder and a variant without tag and with a
// 20-bit tick count, driven by directed and random frames against a field-level model.
module tb_axis_stat_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [1:0][7:0] tdata;
   logic [1:0]      tvalid, tlast, tuser, m_ready;
   logic [1:0]      tready, mv, busy, es, el, eb;
   logic [15:0]     tag0, tag1;
   logic [31:0]     tick0;
   logic [19:0]     tick1;
   logic [31:0]     bc0, bc1, fc0, fc1;

   int checks = 0;
   int errors = 0;
   logic [7:0] fq[$];

   axis_stat_decoder u_dut0 (
      .clk(clk), .rst(rst),
      .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
      .s_axis_tlast(tlast[0]), .s_axis_tuser(tuser[0]),
      .m_tag(tag0), .m_tick_count(tick0), .m_byte_count(bc0), .m_frame_count(fc0),
      .m_valid(mv[0]), .m_ready(m_ready[0]), .busy(busy[0]),
      .error_short(es[0]), .error_long(el[0]), .error_bad(eb[0])
   );

   axis_stat_decoder #(.TAG_ENABLE(0), .TICK_COUNT_WIDTH(20)) u_dut1 (
      .clk(clk), .rst(rst),
      .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
      .s_axis_tlast(tlast[1]), .s_axis_tuser(tuser[1]),
      .m_tag(tag1), .m_tick_count(tick1), .m_byte_count(bc1), .m_frame_count(fc1),
      .m_valid(mv[1]), .m_ready(m_ready[1]), .busy(busy[1]),
      .error_short(es[1]), .error_long(el[1]), .error_bad(eb[1])
   );

   // Field configuration of each instance: field 0 tag, 1 tick, 2 byte, 3 frame.
   function automatic bit fen(int s, int f);
      return !(s == 1 && f == 0);
   endfunction

   function automatic int fw(int s, int f);
      if (f == 0) return 16;
      if (s == 1 && f == 1) return 20;
      return 32;
   endfunction

   function automatic logic [31:0] expect_field(int s, int f, logic [31:0] v);
      if (!fen(s, f)) return 32'd0;
      if (fw(s, f) >= 32) return v;
      return v & ((32'd1 << fw(s, f)) - 32'd1);
   endfunction

   function automatic logic [31:0] obs_field(int s, int f);
      if (s == 0) begin
         case (f)
            0:       return 32'(tag0);
            1:       return tick0;
            2:       return bc0;
            default: return fc0;
         endcase
      end
      case (f)
         0:       return 32'(tag1);
         1:       return 32'(tick1);
         2:       return bc1;
         default: return fc1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Frame image from the field values: ceil(W/8) bytes per enabled field, MSB first.
   task automatic build(int s, logic [31:0] v[4]);
      fq.delete();
      for (int f = 0; f < 4; f++) begin
         if (fen(s, f)) begin
            for (int k = (fw(s, f) + 7) / 8 - 1; k >= 0; k--) begin
               fq.push_back(8'((v[f] >> (8 * k)) & 32'hFF));
            end
         end
      end
   endtask

   task automatic send_byte(int s, logic [7:0] d, bit l, bit u, output bit ok);
      tdata[s]  = d;
      tlast[s]  = l;
      tuser[s]  = u;
      tvalid[s] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (tready[s]) ok = 1'b1;
         tick();
      end
      tvalid[s] = 1'b0;
      tlast[s]  = 1'b0;
      tuser[s]  = 1'b0;
      if (!ok) check($sformatf("i%0d_handshake_timeout", s), 32'(ok), 32'd1);
   endtask

   task automatic send_frame(int s, logic [31:0] v[4], int n, bit ubad, bit gaps);
      int tl;
      bit ok;
      build(s, v);
      tl = fq.size();
      while (fq.size() > n) void'(fq.pop_back());
      while (fq.size() < n) fq.push_back(8'($urandom));
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         send_byte(s, fq[i], i == n - 1, (i == n - 1) ? ubad : 1'($urandom_range(0, 1)), ok);
         if (i == 0 && n > 1) check($sformatf("i%0d_busy_in_frame", s), 32'(busy[s]), 32'd1);
         if (i == tl - 1 && n > tl) check($sformatf("i%0d_err_long", s), 32'(el[s]), 32'd1);
      end
      if (n < tl) begin
         check($sformatf("i%0d_err_short", s), 32'(es[s]), 32'd1);
         check($sformatf("i%0d_short_no_valid", s), 32'(mv[s]), 32'd0);
         tick();
         check($sformatf("i%0d_err_short_pulse", s), 32'(es[s]), 32'd0);
      end else if (n > tl) begin
         check($sformatf("i%0d_drop_no_pulse", s), 32'({es[s], el[s], eb[s]}), 32'd0);
         check($sformatf("i%0d_long_no_valid", s), 32'(mv[s]), 32'd0);
      end else if (ubad) begin
         check($sformatf("i%0d_err_bad", s), 32'(eb[s]), 32'd1);
         check($sformatf("i%0d_bad_no_valid", s), 32'(mv[s]), 32'd0);
      end else begin
         check($sformatf("i%0d_valid", s), 32'(mv[s]), 32'd1);
         for (int f = 0; f < 4; f++) begin
            check($sformatf("i%0d_field%0d", s, f), obs_field(s, f), expect_field(s, f, v[f]));
         end
         check($sformatf("i%0d_good_no_err", s), 32'({es[s], el[s], eb[s]}), 32'd0);
         if (m_ready[s]) begin
            tick();
            check($sformatf("i%0d_valid_clears", s), 32'(mv[s]), 32'd0);
         end
      end
      check($sformatf("i%0d_idle_after", s), 32'(busy[s]), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v[4];
      logic [31:0] hold;
      bit ok;
      int mode, s, n, tl;

      rst     = 1'b1;
      tdata   = '0;
      tvalid  = '0;
      tlast   = '0;
      tuser   = '0;
      m_ready = 2'b11;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check("reset_valid", 32'(mv), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_errors", 32'({es, el, eb}), 32'd0);
      check("reset_tready", 32'(tready), 32'd3);
      check("reset_tag", 32'(tag0), 32'd0);
      check("reset_counts", tick0 | bc0 | fc0, 32'd0);

      // Nominal decode with the reference byte sequence.
      v = '{32'h1234, 32'h100, 32'h40, 32'h2};
      send_frame(0, v, 14, 1'b0, 1'b0);
      check("nominal_tag", 32'(tag0), 32'h1234);
      check("nominal_frame", fc0, 32'd2);

      // Short frame, then a good one.
      v = '{$urandom, $urandom, $urandom, $urandom};
      send_frame(0, v, 10, 1'b0, 1'b0);
      v = '{$urandom, $urandom, $urandom, $urandom};
      send_frame(0, v, 14, 1'b0, 1'b0);

      // Long frame, then a good one.
      send_frame(0, v, 17, 1'b0, 1'b0);
      v = '{$urandom, $urandom, $urandom, $urandom};
      send_frame(0, v, 14, 1'b0, 1'b0);

      // Bad frame.
      send_frame(0, v, 14, 1'b1, 1'b0);

      // Backpressure: a stalled junk byte must not be taken while results are pending.
      m_ready[0] = 1'b0;
      v = '{$urandom, $urandom, $urandom, $urandom};
      send_frame(0, v, 14, 1'b0, 1'b0);
      hold = v[1];
      tdata[0]  = 8'hA5;
      tvalid[0] = 1'b1;
      repeat (3) tick();
      check("bp_tready_low", 32'(tready[0]), 32'd0);
      check("bp_valid_held", 32'(mv[0]), 32'd1);
      check("bp_tick_stable", tick0, hold);
      tvalid[0]  = 1'b0;
      m_ready[0] = 1'b1;
      tick();
      m_ready[0] = 1'b0;
      check("bp_valid_consumed", 32'(mv[0]), 32'd0);
      check("bp_tready_back", 32'(tready[0]), 32'd1);
      v = '{$urandom, $urandom, $urandom, $urandom};
      send_frame(0, v, 14, 1'b0, 1'b0);
      m_ready[0] = 1'b1;
      tick();
      check("bp_second_consumed", 32'(mv[0]), 32'd0);

      // Reset in the middle of a frame.
      for (int i = 0; i < 5; i++) send_byte(0, 8'($urandom), 1'b0, 1'b0, ok);
      check("midrst_busy", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_idle", 32'(busy[0]), 32'd0);
      check("midrst_valid", 32'(mv[0]), 32'd0);
      v = '{$urandom, $urandom, $urandom, $urandom};
      send_frame(0, v, 14, 1'b0, 1'b0);

      // Variant: no tag, 20-bit tick carried in three bytes with pad nibble.
      v = '{32'h0, 32'h00FABCDE, 32'h11223344, 32'h7};
      send_frame(1, v, 11, 1'b0, 1'b0);
      check("var_tick_abcde", 32'(tick1), 32'hABCDE);
      check("var_tag_zero", 32'(tag1), 32'd0);
      send_frame(1, v, 1, 1'b0, 1'b0);

      // Random frames on both instances.
      for (int r = 0; r < 40; r++) begin
         s    = r % 2;
         tl   = (s == 0) ? 14 : 11;
         mode = $urandom_range(0, 3);
         case (mode)
            0:       n = $urandom_range(1, tl - 1);
            1:       n = $urandom_range(tl + 1, tl + 4);
            default: n = tl;
         endcase
         v = '{$urandom, $urandom, $urandom, $urandom};
         send_frame(s, v, n, mode == 2, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
